uart_stream_engine: RTL and testbench

- Buffered, mode-selectable byte processor placed between an existing uart_rx and uart_tx instance pair in the top level.
- Captures each received word, transforms it according to a runtime mode, queues it in a FIFO and drives the tx handshake back-to-back, so bursts are not dropped.
- Also provides LED status and an overflow/error counter.

---
 rtl/uart_stream_pkg.sv | 9 +
 rtl/uart_stream_engine_sync_fifo.sv | 37 +++
 rtl/uart_stream_engine.sv | 82 ++++++++
 tb/tb_uart_stream_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_stream_pkg.sv
// uart_stream_pkg: shared constants and tx FSM states for the uart stream engine
package uart_stream_pkg;
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_REV  = 2'b11;
  localparam logic [7:0] LED_ERROR = 8'hFF;
  typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, GAP = 2'b10} tx_state_t;
endpackage

// File: rtl/uart_stream_engine_sync_fifo.sv
// sync_fifo: power-of-two FIFO with extra-bit pointers and concurrent push/pop
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign level = wp - rp;
  assign empty = wp == rp;
  assign full  = level == (AW+1)'(FIFO_DEPTH);
  // a pop frees the head slot, so a push into a full FIFO is still accepted
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/uart_stream_engine.sv
// uart_stream_engine: captures rx words, transforms by mode, buffers them and drives uart_tx
module uart_stream_engine
  import uart_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADD_CONST  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_ready,
  input  logic                        rx_error,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic [1:0]                  mode,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_start,
  input  logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]        overflow_cnt,
  output logic [CNT_WIDTH-1:0]        error_cnt,
  output logic [7:0]                  led
);
  logic rx_ready_q, rx_error_q, cap_valid, full, empty, pop, rise, err_rise, drop;
  logic [DATA_WIDTH-1:0] cap_data, xform, rev, head, last_word;
  tx_state_t state;
  always_comb begin
    rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) rev[i] = rx_data[DATA_WIDTH-1-i];
  end
  assign xform = mode == MODE_ADD ? rx_data + DATA_WIDTH'(ADD_CONST) :
                 mode == MODE_INV ? ~rx_data :
                 mode == MODE_REV ? rev : rx_data;
  assign rise     = rx_ready & ~rx_ready_q;
  assign err_rise = rx_error & ~rx_error_q;
  assign pop      = state == SEND & tx_start & tx_done;
  assign drop     = cap_valid & full & ~pop;
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(cap_valid), .pop(pop), .wdata(cap_data),
    .rdata(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_ready_q   <= 1'b0;
      rx_error_q   <= 1'b0;
      cap_valid    <= 1'b0;
      cap_data     <= '0;
      last_word    <= '0;
      overflow_cnt <= '0;
      error_cnt    <= '0;
      led          <= '0;
    end else begin
      rx_ready_q   <= rx_ready;
      rx_error_q   <= rx_error;
      cap_valid    <= rise & ~rx_error;
      cap_data     <= rise ? xform : cap_data;
      last_word    <= cap_valid & ~drop ? cap_data : last_word;
      overflow_cnt <= drop && overflow_cnt != '1 ? overflow_cnt + 1'b1 : overflow_cnt;
      error_cnt    <= err_rise && error_cnt != '1 ? error_cnt + 1'b1 : error_cnt;
      led          <= rx_error ? LED_ERROR : {full, ~empty, last_word[5:0]};
    end
  // tx_data is latched once per word so it stays stable for the whole SEND
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          tx_data <= head;
          state   <= SEND;
        end
        SEND: if (tx_start && tx_done) begin
          tx_start <= 1'b0;
          state    <= GAP;
        end else tx_start <= 1'b1;
        GAP: if (!tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_stream_engine.sv
// tb_uart_stream_engine: directed checks on a 16-deep and a 4-deep engine sharing stimulus
module tb_uart_stream_engine;
  logic clk = 1'b0, rst_n = 1'b0, rx_ready = 1'b0, rx_error = 1'b0, tx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic [1:0] mode = '0;
  logic [7:0] tx_data, overflow_cnt, error_cnt, led, s_tx_data, s_overflow_cnt, s_error_cnt, s_led;
  logic tx_start, s_tx_start;
  logic [4:0] fifo_level;
  logic [2:0] s_fifo_level;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  uart_stream_engine #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADD_CONST(1), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_error(rx_error), .rx_data(rx_data),
    .mode(mode), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .error_cnt(error_cnt), .led(led)
  );
  uart_stream_engine #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ADD_CONST(1), .CNT_WIDTH(8)) u_small (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_error(rx_error), .rx_data(rx_data),
    .mode(mode), .tx_data(s_tx_data), .tx_start(s_tx_start), .tx_done(tx_done),
    .fifo_level(s_fifo_level), .overflow_cnt(s_overflow_cnt), .error_cnt(s_error_cnt), .led(s_led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    rx_data = d;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic wait_start(input bit sm, input string tag);
    int n = 0;
    while (((sm ? s_tx_start : tx_start) !== 1'b1) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 100), 32'd1);
  endtask

  task automatic expect_tx(input bit sm, input logic [7:0] exp, input string tag);
    wait_start(sm, tag);
    chk(tag, sm ? s_tx_data : tx_data, exp);
    pulse_done();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_err", error_cnt, 0);
    chk("rst_led", led, 0);
    rst_n = 1'b1;
    tick();

    // add mode, single word, latency 4
    mode = 2'b01;
    rx_data = 8'h41;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    chk("lat_level1", fifo_level, 1);
    tick();
    chk("lat_start_c3", tx_start, 0);
    tick();
    chk("lat_start_c4", tx_start, 1);
    chk("add_41", tx_data, 8'h42);
    chk("led_busy", led, 8'h42);
    repeat (10) tick();
    chk("hold_data", tx_data, 8'h42);
    tx_done = 1'b1;
    tick();
    chk("done_start_low", tx_start, 0);
    chk("done_level0", fifo_level, 0);
    tx_done = 1'b0;
    tick();
    tick();
    chk("led_idle", led, 8'h02);

    // invert burst with tx stalled
    mode = 2'b10;
    send(8'h00);
    send(8'h01);
    send(8'h7F);
    send(8'h80);
    send(8'hFF);
    tick();
    chk("burst_level5", fifo_level, 5);
    expect_tx(0, 8'hFF, "inv_00");
    expect_tx(0, 8'hFE, "inv_01");
    expect_tx(0, 8'h80, "inv_7F");
    expect_tx(0, 8'h7F, "inv_80");
    expect_tx(0, 8'h00, "inv_FF");
    tick();
    chk("burst_drained", fifo_level, 0);

    // long rx_ready pulse pushes once
    mode = 2'b00;
    rx_data = 8'h5A;
    rx_ready = 1'b1;
    repeat (50) tick();
    rx_ready = 1'b0;
    tick();
    tick();
    chk("long_level1", fifo_level, 1);
    chk("long_data", tx_data, 8'h5A);
    pulse_done();
    tick();
    chk("long_level0", fifo_level, 0);
    chk("long_idle", tx_start, 0);

    // rx_ready rise during rx_error discards the word
    rx_error = 1'b1;
    send(8'h33);
    tick();
    chk("err_no_push", fifo_level, 0);
    chk("err_cnt1", error_cnt, 1);
    chk("err_led", led, 8'hFF);
    rx_error = 1'b0;
    tick();
    tick();
    chk("err_led_clear", led, 8'h1A);
    chk("err_cnt_hold", error_cnt, 1);

    // reverse, then add with wrap; mode change after the first capture
    mode = 2'b11;
    send(8'h01);
    mode = 2'b01;
    send(8'hFF);
    expect_tx(0, 8'h80, "rev_01");
    expect_tx(0, 8'h00, "add_wrap");

    // overflow on the 4-deep instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mode = 2'b00;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    tick();
    tick();
    chk("ovf_cnt2", s_overflow_cnt, 2);
    chk("ovf_level4", s_fifo_level, 4);
    chk("ovf_led_full", s_led, 8'hD3);
    chk("ovf_big_none", overflow_cnt, 0);
    expect_tx(1, 8'h10, "ovf_w0");
    expect_tx(1, 8'h11, "ovf_w1");
    expect_tx(1, 8'h12, "ovf_w2");
    expect_tx(1, 8'h13, "ovf_w3");
    tick();
    chk("ovf_drained", s_fifo_level, 0);
    chk("ovf_cnt_hold", s_overflow_cnt, 2);
    expect_tx(0, 8'h14, "big_w4");
    expect_tx(0, 8'h15, "big_w5");

    // async reset during SEND
    send(8'h77);
    wait_start(0, "rst_send");
    chk("rst_send_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_start", tx_start, 0);
    chk("rst_async_level", fifo_level, 0);
    chk("rst_async_ovf4", s_overflow_cnt, 0);
    chk("rst_async_err", error_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h3C);
    expect_tx(0, 8'h3C, "post_rst");
    tick();
    chk("post_rst_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
